// File: rtl/dmem_bus_arbiter.sv
// Round-robin arbiter for the single-ported data-memory bus: port 0 = CPU, port 1 = DMA/loader.
// Latency: issue one cycle after grant, ack the cycle after; requesters are held (stall0) until ack.
module dmem_bus_arbiter #(
   parameter int AW = 13,
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req0,
   input  logic [AW-1:0]   addr0,
   input  logic [3:0]      we0,
   input  logic [DW-1:0]   wdata0,
   output logic            ack0,
   output logic            stall0,
   input  logic            req1,
   input  logic [AW-1:0]   addr1,
   input  logic [3:0]      we1,
   input  logic [DW-1:0]   wdata1,
   output logic            ack1,
   output logic [DW-1:0]   rdata,
   output logic            mem_en,
   output logic [3:0]      mem_we,
   output logic [AW-3:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata,
   output logic [CW-1:0]   cont_cnt
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t state;
   logic   owner;
   logic   last;
   logic   pend0, pend1, anyPend, win;

   // In the ack cycle the owner's req still belongs to the finished access, so it is masked.
   always_comb begin
      pend0 = req0;
      pend1 = req1;
      if (state == ISSUE) begin
         pend0 = 1'b0;
         pend1 = 1'b0;
      end else if (state == RESP) begin
         if (owner) pend1 = 1'b0;
         else       pend0 = 1'b0;
      end
      anyPend = pend0 | pend1;
      win     = (pend0 & pend1) ? ~last : pend1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         owner     <= 1'b0;
         last      <= 1'b1;
         cont_cnt  <= '0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if (req0 && req1 && !(&cont_cnt))
            cont_cnt <= cont_cnt + 1'b1;

         ack0      <= 1'b0;
         ack1      <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;

         unique case (state)
            IDLE:    state <= anyPend ? ISSUE : IDLE;
            ISSUE: begin
               state <= RESP;
               ack0  <= ~owner;
               ack1  <= owner;
            end
            RESP: begin
               last  <= owner;
               state <= anyPend ? ISSUE : IDLE;
            end
            default: state <= IDLE;
         endcase

         // Grant: bus outputs are registered so the ISSUE cycle drives them straight from flops.
         if (anyPend) begin
            owner     <= win;
            mem_en    <= 1'b1;
            mem_we    <= win ? we1 : we0;
            mem_addr  <= win ? addr1[AW-1:2] : addr0[AW-1:2];
            mem_wdata <= win ? wdata1 : wdata0;
         end
      end
   end

   assign stall0 = req0 & ~ack0;
   assign rdata  = (ack0 | ack1) ? mem_rdata : '0;

endmodule
